alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter LEN, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries; must be a power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO can accept.
REQ-007 cmd_op  input  4  ALU opcode.
REQ-008 cmd_a, cmd_b  input  LEN each  operands.
REQ-009 alu_op  output  4  opcode driven to the downstream ALU.
REQ-010 alu_a, alu_b  output  LEN each  operands driven to the ALU.
REQ-011 alu_result  input  LEN  ALU Result.
REQ-012 alu_carry, alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-013 res_valid  output  1  result register holds data.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_data  output  LEN  captured result.
REQ-016 res_flags  output  3  captured flags, ordered {carry, zero, overflow}.
REQ-017 res_err  output  1  result came from an illegal opcode.
REQ-018 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 The pipeline SHALL have three stages: command FIFO -> issue register -> result register, strictly in order.
REQ-020 Push SHALL occur on a rising edge when cmd_valid && cmd_ready.
REQ-021 cmd_ready SHALL equal fifo_count < DEPTH, with no same-cycle pop credit.
REQ-022 Issue-register advance SHALL be defined as adv = iss_valid && (!res_valid || res_ready).
REQ-023 The issue register SHALL load the FIFO head (pop) when the FIFO is non-empty && (!iss_valid || adv); otherwise iss_valid SHALL clear on adv.
REQ-024 alu_op, alu_a and alu_b SHALL be driven directly from the issue register and SHALL hold stable while it is not advancing.
REQ-025 On adv the result register SHALL capture alu_result and the three flags, and res_valid SHALL be set.
REQ-026 Without adv, a res_valid && res_ready handshake SHALL clear res_valid.
REQ-027 res_data, res_flags and res_err SHALL hold stable while res_valid && !res_ready.
REQ-028 Legal opcodes SHALL be 4'b0000 through 4'b0111.
REQ-029 An issued opcode with op[3]=1 SHALL capture res_data=0, res_flags=3'b000 and res_err=1; legal opcodes SHALL capture res_err=0.
REQ-030 Latency: a command pushed at edge E0 into an idle pipe SHALL load the issue register at E0+1 and assert res_valid after E0+2.
REQ-031 Throughput SHALL be 1 result per cycle when res_ready=1 continuously.
REQ-032 A simultaneous push and pop SHALL leave fifo_count unchanged, and pointers SHALL wrap modulo DEPTH.
REQ-033 Total buffering SHALL be DEPTH+2 commands: FIFO, plus issue register, plus result register.
REQ-034 A push while full SHALL be impossible by construction, and a pop while empty SHALL not occur.
REQ-035 No data SHALL bypass the FIFO or the issue register.

Reset
REQ-036 When rst_n=0 at a rising edge, the block SHALL clear fifo_count, the FIFO pointers, iss_valid and res_valid, and drive res_data=0, res_flags=0, res_err=0, alu_op=0, alu_a=0 and alu_b=0.
REQ-037 A reset asserted mid-operation SHALL discard all queued, in-issue and held results, with no result emitted afterward for them.
REQ-038 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-039 The bench SHALL connect the team ALU combinationally between the alu_* ports and cover the scenarios below.
REQ-040 Add: op=0000, a=3, b=5, res_ready=1 -> res_valid 2 cycles after accept, res_data=8, flags=000, res_err=0.
REQ-041 Sub/zero: op=0001, a=5, b=5 -> res_data=0, flags=010.
REQ-042 Overflow: op=0000, a=0x7FFFFFFF, b=1 -> res_data=0x80000000, flags=001.
REQ-043 Backpressure: res_ready=0, offer 8 back-to-back commands with a=i, b=0, op=0000 -> exactly 6 accepted, cmd_ready=0, fifo_count=4; then res_ready=1 -> results 0..5 delivered in order on consecutive cycles.
REQ-044 Illegal op: op=1001 between two adds -> middle result res_data=0, res_err=1, neighbours unaffected.
REQ-045 Reset mid-flight: 3 commands queued, rst_n=0 for one edge -> res_valid=0, fifo_count=0, cmd_ready=1, and none of the 3 results ever appear.

Source files
------------

// File: rtl/alu_issue.sv
// In-order issue stage: command FIFO -> issue register -> result register around an external ALU; result valid 2 edges after accept.
// Backpressure: res_ready low holds the result, then the issue register, then fills the FIFO until cmd_ready drops (no pop credit).

// Generic synchronous FIFO; head is read combinationally, pointers wrap modulo DEPTH.
module alu_issue_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop_dat = mem[rptr];

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module alu_issue #(
   parameter int LEN   = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_op,
   input  logic [LEN-1:0]         cmd_a,
   input  logic [LEN-1:0]         cmd_b,
   output logic [3:0]             alu_op,
   output logic [LEN-1:0]         alu_a,
   output logic [LEN-1:0]         alu_b,
   input  logic [LEN-1:0]         alu_result,
   input  logic                   alu_carry,
   input  logic                   alu_zero,
   input  logic                   alu_overflow,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [LEN-1:0]         res_data,
   output logic [2:0]             res_flags,
   output logic                   res_err,
   output logic [$clog2(DEPTH):0] fifo_count
);
   typedef struct packed {
      logic [3:0]     op;
      logic [LEN-1:0] a;
      logic [LEN-1:0] b;
   } cmd_t;

   cmd_t push_cmd;
   cmd_t head_cmd;
   cmd_t iss_cmd;
   logic iss_valid;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic adv;

   assign push_cmd  = {cmd_op, cmd_a, cmd_b};
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign adv       = iss_valid && (!res_valid || res_ready);
   assign pop       = !empty && (!iss_valid || adv);

   alu_issue_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_cmd),
      .pop      (pop),
      .pop_dat  (head_cmd),
      .count    (fifo_count),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iss_valid <= 1'b0;
         iss_cmd   <= '0;
      end else if (pop) begin
         iss_valid <= 1'b1;
         iss_cmd   <= head_cmd;
      end else if (adv) begin
         iss_valid <= 1'b0;
      end
   end

   assign alu_op = iss_cmd.op;
   assign alu_a  = iss_cmd.a;
   assign alu_b  = iss_cmd.b;

   // Illegal opcodes (op[3]=1) discard whatever the ALU produced.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_flags <= '0;
         res_err   <= 1'b0;
      end else if (adv) begin
         res_valid <= 1'b1;
         res_err   <= iss_cmd.op[3];
         if (iss_cmd.op[3]) begin
            res_data  <= '0;
            res_flags <= '0;
         end else begin
            res_data  <= alu_result;
            res_flags <= {alu_carry, alu_zero, alu_overflow};
         end
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_issue;
   localparam int LEN   = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [3:0]      cmd_op = '0;
   logic [LEN-1:0]  cmd_a = '0;
   logic [LEN-1:0]  cmd_b = '0;
   logic [3:0]      alu_op;
   logic [LEN-1:0]  alu_a;
   logic [LEN-1:0]  alu_b;
   logic [LEN-1:0]  alu_result;
   logic            alu_carry;
   logic            alu_zero;
   logic            alu_overflow;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [LEN-1:0]  res_data;
   logic [2:0]      res_flags;
   logic            res_err;
   logic [$clog2(DEPTH):0] fifo_count;

   int n_pass  = 0;
   int n_total = 0;

   typedef logic [LEN+3:0] exp_t;   // {err, flags[2:0], data}
   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_issue #(.LEN(LEN), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_flags    (res_flags),
      .res_err      (res_err),
      .fifo_count   (fifo_count)
   );

   // Team ALU: returns {carry, zero, overflow, result}; illegal opcodes produce deliberate garbage.
   function automatic logic [LEN+2:0] alu_fn(input logic [3:0] op, input logic [LEN-1:0] a,
                                             input logic [LEN-1:0] b);
      logic [LEN-1:0] r;
      logic           c;
      logic           v;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            {c, r} = {1'b0, a} + {1'b0, b};
            v = (a[LEN-1] == b[LEN-1]) && (r[LEN-1] != a[LEN-1]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[LEN-1] != b[LEN-1]) && (r[LEN-1] != a[LEN-1]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = {{(LEN-1){1'b0}}, ($signed(a) < $signed(b))};
         default: begin
            r = ~a;
            c = 1'b1;
            v = 1'b1;
         end
      endcase
      if (op[3]) return {3'b111, r};
      return {c, (r == '0), v, r};
   endfunction

   function automatic exp_t expect_fn(input logic [3:0] op, input logic [LEN-1:0] a,
                                      input logic [LEN-1:0] b);
      logic [LEN+2:0] t;
      if (op[3]) return {1'b1, 3'b000, {LEN{1'b0}}};
      t = alu_fn(op, a, b);
      return {1'b0, t[LEN+2:LEN], t[LEN-1:0]};
   endfunction

   always_comb {alu_carry, alu_zero, alu_overflow, alu_result} = alu_fn(alu_op, alu_a, alu_b);

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      n_total++;
      if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", res_valid);
      else n_pass++;
      n_total++;
      if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count got %0d want 0", fifo_count);
      else n_pass++;
      n_total++;
      if ({alu_op, alu_a, alu_b} !== '0)
         $display("FAIL reset_alu_regs got op=%0h a=%0h b=%0h want 0", alu_op, alu_a, alu_b);
      else n_pass++;
      n_total++;
      if ({res_data, res_flags, res_err} !== '0)
         $display("FAIL reset_res_regs got d=%0h f=%b e=%0b want 0", res_data, res_flags, res_err);
      else n_pass++;
   endtask

   task automatic test_add();
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = 4'd0;
      cmd_a = 3;
      cmd_b = 5;
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL add_ready_after_reset got %0b want 1", cmd_ready);
      else n_pass++;
      tick();
      cmd_valid = 1'b0;
      n_total++;
      if (fifo_count !== 3'd1 || res_valid !== 1'b0)
         $display("FAIL add_e0 got count=%0d vld=%0b want 1/0", fifo_count, res_valid);
      else n_pass++;
      tick();
      n_total++;
      if (alu_op !== 4'd0 || alu_a !== 3 || alu_b !== 5 || res_valid !== 1'b0 || fifo_count !== 3'd0)
         $display("FAIL add_issue got op=%0d a=%0d b=%0d vld=%0b cnt=%0d want 0/3/5/0/0",
                  alu_op, alu_a, alu_b, res_valid, fifo_count);
      else n_pass++;
      tick();
      n_total++;
      if (res_valid !== 1'b1 || res_data !== 8 || res_flags !== 3'b000 || res_err !== 1'b0)
         $display("FAIL add_result got vld=%0b d=%0d f=%b e=%0b want 1/8/000/0",
                  res_valid, res_data, res_flags, res_err);
      else n_pass++;
      tick();
      n_total++;
      if (res_valid !== 1'b0) $display("FAIL add_consumed got vld=%0b want 0", res_valid);
      else n_pass++;
   endtask

   task automatic test_flags();
      logic [3:0]     t_op [2] = '{4'd1, 4'd0};
      logic [LEN-1:0] t_a  [2] = '{32'd5, 32'h7FFF_FFFF};
      logic [LEN-1:0] t_b  [2] = '{32'd5, 32'd1};
      logic [LEN-1:0] t_d  [2] = '{32'd0, 32'h8000_0000};
      logic [2:0]     t_f  [2] = '{3'b010, 3'b001};
      res_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cmd_valid = 1'b1;
         cmd_op = t_op[k];
         cmd_a = t_a[k];
         cmd_b = t_b[k];
         tick();
         cmd_valid = 1'b0;
         repeat (2) tick();
         n_total++;
         if (res_valid !== 1'b1 || res_data !== t_d[k] || res_flags !== t_f[k] || res_err !== 1'b0)
            $display("FAIL flags_%0d got vld=%0b d=%0h f=%b e=%0b want 1/%0h/%b/0",
                     k, res_valid, res_data, res_flags, res_err, t_d[k], t_f[k]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cmd_valid = 1'b1;
         cmd_op = 4'd0;
         cmd_a = i;
         cmd_b = 0;
         if (cmd_ready) acc++;
         tick();
      end
      cmd_valid = 1'b0;
      n_total++;
      if (acc !== 6) $display("FAIL bp_accepted got %0d want 6", acc);
      else n_pass++;
      n_total++;
      if (cmd_ready !== 1'b0 || fifo_count !== 3'd4)
         $display("FAIL bp_full got rdy=%0b cnt=%0d want 0/4", cmd_ready, fifo_count);
      else n_pass++;
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (res_valid !== 1'b1 || res_data !== i)
            $display("FAIL bp_drain_%0d got vld=%0b d=%0d want 1/%0d", i, res_valid, res_data, i);
         else n_pass++;
         tick();
      end
      n_total++;
      if (res_valid !== 1'b0 || fifo_count !== 3'd0)
         $display("FAIL bp_empty got vld=%0b cnt=%0d want 0/0", res_valid, fifo_count);
      else n_pass++;
   endtask

   task automatic test_illegal();
      logic [3:0]     t_op [3] = '{4'd0, 4'b1001, 4'd0};
      logic [LEN-1:0] t_a  [3] = '{32'd1, 32'h55, 32'd10};
      logic [LEN-1:0] t_b  [3] = '{32'd2, 32'h22, 32'd20};
      exp_t           want [3] = '{{1'b0, 3'b000, 32'd3}, {1'b1, 3'b000, 32'd0}, {1'b0, 3'b000, 32'd30}};
      exp_t           got  [3];
      int k = 0;
      res_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         cmd_valid = (cyc < 3);
         if (cyc < 3) begin
            cmd_op = t_op[cyc];
            cmd_a = t_a[cyc];
            cmd_b = t_b[cyc];
         end
         if (res_valid && k < 3) begin
            got[k] = {res_err, res_flags, res_data};
            k++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      n_total++;
      if (k !== 3) $display("FAIL illegal_count got %0d want 3", k);
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (j >= k || got[j] !== want[j])
            $display("FAIL illegal_res_%0d got %0h want %0h", j, got[j], want[j]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1;
         cmd_op = 4'd0;
         cmd_a = 100 + i;
         cmd_b = 0;
         tick();
      end
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_total++;
      if (res_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1)
         $display("FAIL midrst_state got vld=%0b cnt=%0d rdy=%0b want 0/0/1", res_valid, fifo_count, cmd_ready);
      else n_pass++;
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (res_valid) seen++;
         tick();
      end
      n_total++;
      if (seen !== 0) $display("FAIL midrst_ghost got %0d results want 0", seen);
      else n_pass++;
   endtask

   task automatic test_random();
      exp_t held = '0;
      logic held_vld = 1'b0;
      exp_t e;
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_op = 4'($urandom_range(0, 15));
         cmd_a = $urandom;
         cmd_b = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom;
         res_ready = ($urandom_range(0, 2) != 0);
         if (held_vld) begin
            n_total++;
            if ({res_err, res_flags, res_data} !== held || res_valid !== 1'b1)
               $display("FAIL rand_hold c=%0d got %0h want %0h", c, {res_err, res_flags, res_data}, held);
            else n_pass++;
         end
         if (res_valid && res_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL rand_unexpected c=%0d got %0h want none", c, {res_err, res_flags, res_data});
            end else begin
               e = exp_q.pop_front();
               if ({res_err, res_flags, res_data} !== e)
                  $display("FAIL rand_result c=%0d got %0h want %0h", c, {res_err, res_flags, res_data}, e);
               else n_pass++;
            end
         end
         if (cmd_valid && cmd_ready) exp_q.push_back(expect_fn(cmd_op, cmd_a, cmd_b));
         n_total++;
         if (exp_q.size() > DEPTH + 2 || fifo_count > 3'(DEPTH))
            $display("FAIL rand_occupancy c=%0d got q=%0d cnt=%0d want <=%0d/<=%0d",
                     c, exp_q.size(), fifo_count, DEPTH + 2, DEPTH);
         else n_pass++;
         held_vld = res_valid && !res_ready;
         held = {res_err, res_flags, res_data};
         tick();
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (res_valid) begin
            e = exp_q.pop_front();
            n_total++;
            if ({res_err, res_flags, res_data} !== e)
               $display("FAIL rand_drain got %0h want %0h", {res_err, res_flags, res_data}, e);
            else n_pass++;
         end
         tick();
      end
      n_total++;
      if (exp_q.size() != 0 || res_valid !== 1'b0)
         $display("FAIL rand_leftover got q=%0d vld=%0b want 0/0", exp_q.size(), res_valid);
      else n_pass++;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_add();
      test_flags();
      test_backpressure();
      test_illegal();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
